// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic-light controller and its input conditioning.
package traffic_pkg;

    typedef enum logic {LOW, HIGH} senseState;

    localparam int unsigned TRAFFIC_CLK_DIV    = 1000;
    localparam int unsigned TRAFFIC_STABLE_CNT = 4;

    localparam logic [1:0] GREEN  = 2'b00;
    localparam logic [1:0] YELLOW = 2'b01;
    localparam logic [1:0] RED    = 2'b10;

endpackage

// File: rtl/traffic_debounce_ch.sv
// One sensor channel: two-flop synchroniser followed by a tick-driven stability filter.
module traffic_debounce_ch
    import traffic_pkg::*;
#(
    parameter int unsigned STABLE_CNT = TRAFFIC_STABLE_CNT
) (
    input  logic clk,
    input  logic NOT_RESET,
    input  logic tick,
    input  logic raw,
    output logic level
);

    localparam int unsigned CntW = $clog2(STABLE_CNT + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(STABLE_CNT - 1);

    logic            s1;
    logic            s2;
    senseState       state_q;
    senseState       state_d;
    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;

    always_ff @(posedge clk or negedge NOT_RESET) begin
        if (!NOT_RESET) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    always_ff @(posedge clk or negedge NOT_RESET) begin
        if (!NOT_RESET) begin
            state_q <= LOW;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Any agreeing sample restarts the window; only STABLE_CNT differing ticks in a row flip.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (tick) begin
            if (s2 == (state_q == HIGH)) begin
                cnt_d = '0;
            end else if (cnt_q == CntLast) begin
                state_d = (state_q == LOW) ? HIGH : LOW;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        level = (state_q == HIGH);
    end

endmodule

// File: rtl/traffic_sensor_conditioner.sv
// Synchronises and debounces the four traffic-controller pad inputs on a shared sample tick.
// Define TRAFFIC_SENSE_PULSE_EN to turn P and R into single-cycle rising-edge pulses.
module traffic_sensor_conditioner
    import traffic_pkg::*;
#(
    parameter int unsigned CLK_DIV    = TRAFFIC_CLK_DIV,
    parameter int unsigned STABLE_CNT = TRAFFIC_STABLE_CNT
) (
    input  logic clk,
    input  logic NOT_RESET,
    input  logic raw_ta,
    input  logic raw_tb,
    input  logic raw_p,
    input  logic raw_r,
    output logic Ta,
    output logic Tb,
    output logic P,
    output logic R,
    output logic sample_tick
);

    localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

    logic [DivW-1:0] div_q;
    logic            run_q;
    logic            level_ta;
    logic            level_tb;
    logic            level_p;
    logic            level_r;

    always_ff @(posedge clk or negedge NOT_RESET) begin
        if (!NOT_RESET) begin
            div_q <= '0;
            run_q <= 1'b0;
        end else begin
            div_q <= (div_q == DivLast) ? '0 : div_q + 1'b1;
            run_q <= 1'b1;
        end
    end

    // run_q keeps the tick low in reset, which matters when CLK_DIV is 1 and the count is pinned.
    assign sample_tick = run_q && (div_q == DivLast);

    traffic_debounce_ch #(.STABLE_CNT(STABLE_CNT)) u_ch_ta (
        .clk       (clk),
        .NOT_RESET (NOT_RESET),
        .tick      (sample_tick),
        .raw       (raw_ta),
        .level     (level_ta)
    );

    traffic_debounce_ch #(.STABLE_CNT(STABLE_CNT)) u_ch_tb (
        .clk       (clk),
        .NOT_RESET (NOT_RESET),
        .tick      (sample_tick),
        .raw       (raw_tb),
        .level     (level_tb)
    );

    traffic_debounce_ch #(.STABLE_CNT(STABLE_CNT)) u_ch_p (
        .clk       (clk),
        .NOT_RESET (NOT_RESET),
        .tick      (sample_tick),
        .raw       (raw_p),
        .level     (level_p)
    );

    traffic_debounce_ch #(.STABLE_CNT(STABLE_CNT)) u_ch_r (
        .clk       (clk),
        .NOT_RESET (NOT_RESET),
        .tick      (sample_tick),
        .raw       (raw_r),
        .level     (level_r)
    );

    assign Ta = level_ta;
    assign Tb = level_tb;

`ifdef TRAFFIC_SENSE_PULSE_EN
    logic level_p_d;
    logic level_r_d;

    always_ff @(posedge clk or negedge NOT_RESET) begin
        if (!NOT_RESET) begin
            level_p_d <= 1'b0;
            level_r_d <= 1'b0;
        end else begin
            level_p_d <= level_p;
            level_r_d <= level_r;
        end
    end

    assign P = level_p & ~level_p_d;
    assign R = level_r & ~level_r_d;
`else
    assign P = level_p;
    assign R = level_r;
`endif

endmodule
